gray_sweep_checker: RTL
=======================

Name: gray_sweep_checker

Overview:
- Response-side companion to the 4-input binary-to-Gray converter (inputs w,x,y,z; outputs y3..y0).
- Accepts the converter's output words one at a time and decodes each Gray word back to binary.
- Checks each decoded word against the expected exhaustive sweep index 0..N_WORDS-1.
- Counts mismatches and flags completion, turning the open-loop exhaustive sweep into a self-checking one.

Parameters:
- WIDTH, 4, code word width (y3..y0 maps to code_in[3:0]).
- N_WORDS, 16, words per sweep; equals 2**WIDTH.
- CNT_W, 5, width of err_count; must hold N_WORDS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled in IDLE and DONE only.
- in_valid  input  1  code_in is valid this cycle.
- code_in  input  WIDTH  Gray word from the converter; code_in[3]=y3 … code_in[0]=y0.
- in_ready  output  1  checker accepts a word this cycle.
- bin_out  output  WIDTH  decoded binary of the last accepted word.
- out_valid  output  1  one-cycle pulse: bin_out and mismatch are updated.
- mismatch  output  1  qualified by out_valid; decoded word differs from the expected index.
- err_count  output  CNT_W  mismatches in the current or last sweep; saturating.
- exp_idx  output  WIDTH  expected index of the next accepted word.
- done  output  1  sweep complete; held high.

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-sweep. Reset values:
  - state=IDLE; in_ready=0; bin_out=0; out_valid=0; mismatch=0; err_count=0; exp_idx=0; done=0.
  - A sweep interrupted by reset is discarded; no partial result is kept.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: in_ready=0. start=1 -> RUN at the next edge; err_count and exp_idx cleared to 0.
  - RUN: in_ready=1. Accept = in_valid & in_ready. start is ignored. in_valid while not ready is dropped with no side effect.
  - On accept:
    - bin_out <= gray2bin(code_in).
    - mismatch <= (gray2bin(code_in) != exp_idx).
    - out_valid <= 1 for exactly one cycle, so latency is 1 cycle from the accept edge.
    - err_count increments on mismatch, saturating at 2**CNT_W-1.
    - exp_idx increments.
  - Accepting the word with exp_idx = N_WORDS-1 moves the FSM to DONE at the same edge, and exp_idx wraps to 0.
  - DONE: done=1 and in_ready=0; err_count and bin_out are held.
    - start=1 -> RUN with err_count=0, exp_idx=0, and done=0 at that edge.
    - Without start, the FSM stays in DONE indefinitely.
- Decode rule: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i < WIDTH-1. The decoder is purely combinational into the bin_out register.
- Back-to-back accepts (in_valid high every cycle) are supported at full rate: one word per clock, 16 words in 16 cycles.
- out_valid is low whenever no accept occurred on the previous edge. mismatch holds its last value but is meaningful only when out_valid=1.
- If start and in_valid are both high in IDLE or DONE, only the start takes effect; in_valid is ignored that cycle.

Test Plan:
- Reset behaviour: assert rst mid-cycle during RUN at exp_idx=7 -> all outputs go to their reset values immediately, before the next edge; state returns to IDLE.
- Clean sweep: start, then feed Gray words 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8 on consecutive cycles ->
  - bin_out reads 0..15 in order, one cycle after each accept;
  - mismatch=0 on every out_valid pulse;
  - err_count=0;
  - done=1 on the cycle after the 16th accept.
- Single error: same sweep, but the 6th word (idx 5) is 4'b0110 instead of 4'b0111 -> that word decodes to 4, so mismatch=1 on that pulse only; final err_count=1; done=1.
- Gapped input: in_valid toggles 1,0,1,0 through the sweep -> out_valid pulses only after accepts; exp_idx advances only on accepts; 16 accepts complete in 32 cycles with err_count=0.
- Restart: from DONE with err_count=3, pulse start -> done=0, err_count=0, exp_idx=0 at that edge; a fresh clean sweep ends with err_count=0.
- Ignored inputs: in_valid=1 with code 4'b1111 while in IDLE, and start=1 at exp_idx=8 during RUN -> no out_valid pulse, no err_count change, and exp_idx is not reset.

Source files
------------

// File: rtl/gray_sweep_checker_if.sv
// Handshake and result bundle between a Gray-word source and gray_sweep_checker.
// The master side drives start and the code stream. The slave side (the checker)
// returns the ready flag, the decoded result and the sweep status.
interface gray_sweep_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] code_in;
    logic             in_ready;
    logic [WIDTH-1:0] bin_out;
    logic             out_valid;
    logic             mismatch;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH-1:0] exp_idx;
    logic             done;

    modport master (
        output start, in_valid, code_in,
        input  in_ready, bin_out, out_valid, mismatch, err_count, exp_idx, done
    );

    modport slave (
        input  start, in_valid, code_in,
        output in_ready, bin_out, out_valid, mismatch, err_count, exp_idx, done
    );
endinterface

// File: rtl/gray_sweep_checker.sv
// Response-side checker for an exhaustive binary-to-Gray sweep.
// Each accepted Gray word is decoded back to binary and compared against the
// running sweep index. Mismatches are counted, saturating at the counter's maximum.
// The sweep ends after N_WORDS accepts, and done stays high until the next start.
module gray_sweep_checker #(
    parameter int WIDTH   = 4,
    parameter int N_WORDS = 16,
    parameter int CNT_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    gray_sweep_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(N_WORDS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_out_q, bin_out_d;
    logic             out_valid_q, out_valid_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0] exp_idx_q, exp_idx_d;

    logic             in_ready_c;
    logic             done_c;
    logic             accept;
    logic             start_go;
    logic             last_word;
    logic [WIDTH-1:0] dec_bin;

    // The handshake completes only while running. Start matters only in IDLE or
    // DONE, where it takes priority over any in_valid in the same cycle.
    assign accept    = in_ready_c & bus.in_valid;
    assign start_go  = (state_q == S_IDLE || state_q == S_DONE) & bus.start;
    assign last_word = (exp_idx_q == LAST_IDX);

    // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        dec_bin = '0;
        dec_bin[WIDTH-1] = bus.code_in[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            dec_bin[i] = dec_bin[i+1] ^ bus.code_in[i];
        end
    end

    // FSM state register; reset drops any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (accept && last_word) state_d = S_DONE;
            S_DONE:  if (bus.start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: ready only while running, done only after a completed sweep.
    always_comb begin
        in_ready_c = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            S_RUN:   in_ready_c = 1'b1;
            S_DONE:  done_c     = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: start clears the sweep counters; an accept loads the
    // decoded result, scores it and advances the expected index.
    always_comb begin
        bin_out_d   = bin_out_q;
        out_valid_d = 1'b0;
        mismatch_d  = mismatch_q;
        err_count_d = err_count_q;
        exp_idx_d   = exp_idx_q;
        if (start_go) begin
            err_count_d = '0;
            exp_idx_d   = '0;
        end else if (accept) begin
            bin_out_d   = dec_bin;
            out_valid_d = 1'b1;
            mismatch_d  = (dec_bin != exp_idx_q);
            if ((dec_bin != exp_idx_q) && (err_count_q != {CNT_W{1'b1}})) begin
                err_count_d = err_count_q + 1'b1;
            end
            // Wraps to 0 naturally on the last word because N_WORDS == 2**WIDTH.
            exp_idx_d   = exp_idx_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out_q   <= '0;
            out_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
            exp_idx_q   <= '0;
        end else begin
            bin_out_q   <= bin_out_d;
            out_valid_q <= out_valid_d;
            mismatch_q  <= mismatch_d;
            err_count_q <= err_count_d;
            exp_idx_q   <= exp_idx_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.done      = done_c;
    assign bus.bin_out   = bin_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.err_count = err_count_q;
    assign bus.exp_idx   = exp_idx_q;

endmodule
